// File: rtl/mem_arbiter.sv
// Two-master (I-side, D-side) to one shared memory port arbiter.
// Round-robin grant, latched request, per-transaction ack timeout.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              IM_enable,
    input  logic              IM_read,
    input  logic              IM_write,
    input  logic [ADDR_W-1:0] IM_address,
    output logic [DATA_W-1:0] IM_out,
    output logic              IM_ready,
    input  logic              DM_enable,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    output logic [DATA_W-1:0] DM_out,
    output logic              DM_ready,
    output logic              MEM_enable,
    output logic              MEM_read,
    output logic              MEM_write,
    output logic [ADDR_W-1:0] MEM_address,
    output logic [DATA_W-1:0] MEM_in,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic              MEM_ack,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_dm_q;
    logic                owner_dm_q;
    logic                op_wr_q;
    logic                mem_enable_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   im_out_q;
    logic [DATA_W-1:0]   dm_out_q;
    logic                im_ready_q;
    logic                dm_ready_q;
    logic                timeout_err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                grant_im;
    logic                grant_dm;
    logic                hit_timeout;

    // On a tie the side that did not win last time is granted.
    assign grant_dm = DM_enable & (~IM_enable | ~last_dm_q);
    assign grant_im = IM_enable & (~DM_enable |  last_dm_q);

    assign cnt_d       = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign hit_timeout = (cnt_d == CNT_W'(TIMEOUT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            last_dm_q     <= 1'b0;
            owner_dm_q    <= 1'b0;
            op_wr_q       <= 1'b0;
            mem_enable_q  <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            im_out_q      <= '0;
            dm_out_q      <= '0;
            im_ready_q    <= 1'b0;
            dm_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            im_ready_q    <= 1'b0;
            dm_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_im || grant_dm) begin
                        owner_dm_q   <= grant_dm;
                        last_dm_q    <= grant_dm;
                        addr_q       <= grant_dm ? DM_address : IM_address;
                        wdata_q      <= grant_dm ? DM_in : '0;
                        // Read wins when both read and write are set; neither means read.
                        op_wr_q      <= grant_dm ? (DM_write & ~DM_read)
                                                 : (IM_write & ~IM_read);
                        cnt_q        <= '0;
                        mem_enable_q <= 1'b1;
                        state_q      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (MEM_ack || hit_timeout) begin
                        if (owner_dm_q) begin
                            dm_out_q   <= MEM_ack ? MEM_out : ERR_DATA;
                            dm_ready_q <= 1'b1;
                        end else begin
                            im_out_q   <= MEM_ack ? MEM_out : ERR_DATA;
                            im_ready_q <= 1'b1;
                        end
                        timeout_err_q <= ~MEM_ack;
                        mem_enable_q  <= 1'b0;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_enable_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign MEM_enable  = mem_enable_q;
    assign MEM_read    = mem_enable_q & ~op_wr_q;
    assign MEM_write   = mem_enable_q &  op_wr_q;
    assign MEM_address = addr_q;
    assign MEM_in      = wdata_q;
    assign IM_out      = im_out_q;
    assign DM_out      = dm_out_q;
    assign IM_ready    = im_ready_q;
    assign DM_ready    = dm_ready_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard queue,
// with hand-written sequences for reset behaviour.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        IM_enable = 1'b0, IM_read = 1'b0, IM_write = 1'b0;
    logic [31:0] IM_address = '0;
    logic [31:0] IM_out;
    logic        IM_ready;
    logic        DM_enable = 1'b0, DM_read = 1'b0, DM_write = 1'b0;
    logic [31:0] DM_address = '0, DM_in = '0;
    logic [31:0] DM_out;
    logic        DM_ready;
    logic        MEM_enable, MEM_read, MEM_write;
    logic [31:0] MEM_address, MEM_in;
    logic [31:0] MEM_out = '0;
    logic        MEM_ack = 1'b0;
    logic        timeout_err;

    always #5 clock = ~clock;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)) dut (
        .clock(clock), .reset(reset),
        .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
        .IM_address(IM_address), .IM_out(IM_out), .IM_ready(IM_ready),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out), .DM_ready(DM_ready),
        .MEM_enable(MEM_enable), .MEM_read(MEM_read), .MEM_write(MEM_write),
        .MEM_address(MEM_address), .MEM_in(MEM_in), .MEM_out(MEM_out),
        .MEM_ack(MEM_ack), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        ie, ir, iw;
        logic [31:0] ia;
        logic        de, dr, dw;
        logic [31:0] da, dd;
        int          lat;      // BUSY cycle carrying the ack, 0 = never ack
        logic [31:0] mdata;
        logic        hold;     // keep enables asserted after completion
        logic        exp_dm;
        logic        exp_wr;
        logic [31:0] exp_addr, exp_min, exp_out;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic        dm;
        logic [31:0] out;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ie, ir, iw, input logic [31:0] ia,
        input logic de, dr, dw, input logic [31:0] da, dd,
        input int lat, input logic [31:0] mdata, input logic hold,
        input logic exp_dm, exp_wr, input logic [31:0] exp_addr, exp_min, exp_out,
        input logic exp_to);
        vec_t v;
        v.ie = ie; v.ir = ir; v.iw = iw; v.ia = ia;
        v.de = de; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.lat = lat; v.mdata = mdata; v.hold = hold;
        v.exp_dm = exp_dm; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
        v.exp_min = exp_min; v.exp_out = exp_out; v.exp_to = exp_to;
        return v;
    endfunction

    // Called on a falling edge while the arbiter is IDLE; returns on the
    // falling edge of the IDLE cycle following DONE.
    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          b;
        int          bad;
        bit          done;
        exp_t        e;
        exp_t        got;
        logic [31:0] other_before;
        int          exp_lat;
        IM_enable = v.ie; IM_read = v.ir; IM_write = v.iw; IM_address = v.ia;
        DM_enable = v.de; DM_read = v.dr; DM_write = v.dw; DM_address = v.da; DM_in = v.dd;
        MEM_ack = 1'b0;
        e.dm = v.exp_dm; e.out = v.exp_out; e.to = v.exp_to;
        sb.push_back(e);
        other_before = v.exp_dm ? IM_out : DM_out;
        exp_lat = (v.lat == 0) ? TIMEOUT + 1 : v.lat + 1;
        n = 0; b = 0; bad = 0; done = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
            MEM_ack = 1'b0;
            if (IM_ready || DM_ready) begin
                done = 1;
            end else if (MEM_enable) begin
                b++;
                if (MEM_read !== ~v.exp_wr || MEM_write !== v.exp_wr ||
                    MEM_address !== v.exp_addr || MEM_in !== v.exp_min)
                    bad++;
                if (b == v.lat) begin
                    MEM_ack = 1'b1;
                    MEM_out = v.mdata;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_no_ready: got none expected ready within 300 cycles", idx);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        chk($sformatf("vec%0d_ready_owner", idx), {30'd0, IM_ready, DM_ready},
            got.dm ? 32'd1 : 32'd2);
        chk($sformatf("vec%0d_out", idx), got.dm ? DM_out : IM_out, got.out);
        chk($sformatf("vec%0d_timeout_err", idx), {31'd0, timeout_err}, {31'd0, got.to});
        chk($sformatf("vec%0d_latency", idx), n, exp_lat);
        chk($sformatf("vec%0d_mem_fields_bad_cycles", idx), bad, 0);
        chk($sformatf("vec%0d_other_out_hold", idx), got.dm ? IM_out : DM_out, other_before);
        $display("vec%0d owner=%s addr=0x%08h out=0x%08h to=%0d latency=%0d",
                 idx, got.dm ? "D" : "I", v.exp_addr, got.dm ? DM_out : IM_out,
                 timeout_err, n);
        if (!v.hold) begin
            IM_enable = 1'b0;
            DM_enable = 1'b0;
        end
        @(negedge clock);
        chk($sformatf("vec%0d_after_done_quiet", idx),
            {28'd0, IM_ready, DM_ready, timeout_err, MEM_enable}, 32'd0);
    endtask

    initial begin
        int b;
        int n;
        int bad;

        vecs[0]  = mk(1,1,0,32'h100,  0,0,0,32'h0,0,          1,32'h12345678,0, 0,0,32'h100, 0,32'h12345678,0);
        vecs[1]  = mk(0,0,0,32'h0,    1,0,1,32'h2000,32'hCAFEF00D, 4,32'h11112222,0, 1,1,32'h2000,32'hCAFEF00D,32'h11112222,0);
        vecs[2]  = mk(0,0,0,32'h0,    1,1,1,32'h44,32'h55,    2,32'hA5A5A5A5,0, 1,0,32'h44,  32'h55,32'hA5A5A5A5,0);
        vecs[3]  = mk(1,0,1,32'h304,  0,0,0,32'h0,0,          1,32'h77,0,       0,1,32'h304, 0,32'h77,0);
        vecs[4]  = mk(1,0,0,32'h308,  0,0,0,32'h0,0,          2,32'h0BADF00D,0, 0,0,32'h308, 0,32'h0BADF00D,0);
        vecs[5]  = mk(1,1,0,32'h1000, 1,0,1,32'h2100,32'hD0000001, 1,32'h5,1, 1,1,32'h2100,32'hD0000001,32'h5,0);
        vecs[6]  = mk(1,1,0,32'h1000, 1,0,1,32'h2100,32'hD0000001, 2,32'h6,1, 0,0,32'h1000,0,32'h6,0);
        vecs[7]  = mk(1,1,0,32'h1004, 1,0,1,32'h2104,32'hD0000002, 1,32'h7,1, 1,1,32'h2104,32'hD0000002,32'h7,0);
        vecs[8]  = mk(1,1,0,32'h1004, 1,0,1,32'h2104,32'hD0000002, 3,32'h8,1, 0,0,32'h1004,0,32'h8,0);
        vecs[9]  = mk(1,1,0,32'h1008, 1,0,1,32'h2108,32'hD0000003, 1,32'h9,1, 1,1,32'h2108,32'hD0000003,32'h9,0);
        vecs[10] = mk(1,1,0,32'h1008, 1,0,1,32'h2108,32'hD0000003, 1,32'hA,0, 0,0,32'h1008,0,32'hA,0);
        vecs[11] = mk(0,0,0,32'h0,    1,1,0,32'h3000,32'h0,   0,32'h99,0,       1,0,32'h3000,0,32'hDEADBEEF,1);
        vecs[12] = mk(0,0,0,32'h0,    1,1,0,32'h3004,32'h0,   64,32'h600D600D,0, 1,0,32'h3004,0,32'h600D600D,0);
        vecs[13] = mk(1,1,0,32'h500,  0,0,0,32'h0,0,          1,32'h13,0,       0,0,32'h500, 0,32'h13,0);

        // Reset held with a pending I request: everything stays quiet.
        reset = 1'b0;
        IM_enable = 1'b1; IM_read = 1'b1; IM_address = 32'h100;
        repeat (3) @(negedge clock);
        chk("reset_outputs_zero",
            {26'd0, IM_ready, DM_ready, MEM_enable, MEM_read, MEM_write, timeout_err}, 32'd0);
        chk("reset_mem_address", MEM_address, 32'd0);
        chk("reset_im_out", IM_out, 32'd0);
        chk("reset_dm_out", DM_out, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset in the third BUSY cycle aborts the transaction.
        DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'h4000;
        b = 0; n = 0;
        while (b < 3 && n < 20) begin
            @(negedge clock);
            n++;
            if (MEM_enable) b++;
        end
        chk("midreset_reached_busy3", b, 3);
        reset = 1'b0;
        #1;
        chk("midreset_mem_enable_async", {31'd0, MEM_enable}, 32'd0);
        chk("midreset_dm_out_cleared", DM_out, 32'd0);
        @(negedge clock);
        DM_enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        bad = 0;
        MEM_ack = 1'b1;
        MEM_out = 32'hBAADBAAD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (IM_ready || DM_ready || MEM_enable || timeout_err) bad++;
        end
        MEM_ack = 1'b0;
        chk("midreset_stray_ack_ignored", bad, 0);
        chk("midreset_dm_out_unchanged", DM_out, 32'd0);
        $display("midreset sequence done bad_cycles=%0d", bad);

        run_vec(13, vecs[13]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master, one-slave memory arbiter placed directly downstream of the cpu's external instruction-side (IM_*) and data-side (DM_*) ports. It serialises the I-cache and D-cache refill/writeback requests onto a single shared memory port. It uses round-robin arbitration, a registered request latch and a per-transaction acknowledge timeout. The IOM path does not pass through this block.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 32, address bus width
TIMEOUT, 64, maximum BUSY cycles to wait for MEM_ack before aborting (must be ≥2)
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
IM_enable  input  1  I-side request strobe, held until IM_ready
IM_read  input  1  I-side read
IM_write  input  1  I-side write
IM_address  input  ADDR_W  I-side address
IM_out  output  DATA_W  I-side read data, valid when IM_ready=1
IM_ready  output  1  I-side completion pulse
DM_enable  input  1  D-side request strobe, held until DM_ready
DM_read  input  1  D-side read
DM_write  input  1  D-side write
DM_address  input  ADDR_W  D-side address
DM_in  input  DATA_W  D-side write data
DM_out  output  DATA_W  D-side read data, valid when DM_ready=1
DM_ready  output  1  D-side completion pulse
MEM_enable  output  1  shared memory strobe
MEM_read  output  1  shared memory read
MEM_write  output  1  shared memory write
MEM_address  output  ADDR_W  shared memory address
MEM_in  output  DATA_W  shared memory write data
MEM_out  input  DATA_W  shared memory read data, valid with MEM_ack
MEM_ack  input  1  shared memory completion, any latency
timeout_err  output  1  one-cycle pulse when a transaction aborts on timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; IM_out/DM_out=0; last_grant=I, so D wins the first tie.
  - Reset during BUSY or DONE aborts the transaction. No ready pulse is issued, MEM_enable drops immediately, and any MEM_ack that arrives later is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Each cycle, sample IM_enable and DM_enable.
  - Only one asserted: grant it. Both asserted: grant the side opposite last_grant.
  - On grant, latch owner, address, write data (DM_in for D; 0 for I), op and owner, update last_grant, then go to BUSY.
  - Op rule: read=1 → read (read wins if both read and write are 1); write=1,read=0 → write; neither → read.
- BUSY:
  - MEM_enable=1; MEM_read, MEM_write, MEM_address and MEM_in are driven from the latch only and are stable for the whole of BUSY.
  - Requester inputs are ignored.
  - The timeout counter clears on BUSY entry and increments each BUSY cycle.
  - MEM_ack=1: capture MEM_out into the owner's data register (writes also capture it; the value is don't-care), go to DONE.
  - Counter reaches TIMEOUT without ack: load ERR_DATA, pulse timeout_err, go to DONE.
  - A MEM_ack in the same cycle the counter hits TIMEOUT counts as ack; no error.
- DONE:
  - MEM_enable=0; owner's ready=1 for exactly one cycle with owner's out valid; next state IDLE.
  - Requester must deassert enable after the edge on which it samples ready. In DONE the arbiter ignores both enables, so no back-to-back grant from DONE.
- IM_out/DM_out hold their last value between transactions. The non-owner's ready and out are unaffected.
- Latency: enable sampled in IDLE at cycle N; BUSY at N+1; with ack at N+1, ready at N+2. A memory latency of L ack cycles gives ready at N+1+L.
- Throughput: at most one transaction per 3 cycles. Under continuous contention, I and D alternate strictly, so neither side starves.
- MEM_ack outside BUSY is ignored.
- Arithmetic: counter width is clog2(TIMEOUT+1), saturating; no wrap occurs because exit happens at TIMEOUT.

Test Plan:
- Reset: hold reset=0 with IM_enable=1 → all outputs 0. Release → BUSY next cycle, MEM_address=IM_address, MEM_read=1.
- I read, ack latency 1: IM_address=0x100, MEM_out=0x12345678 with ack in first BUSY cycle → IM_ready pulses at cycle N+2 with IM_out=0x12345678; DM_ready stays 0.
- D write, ack latency 4: DM_write=1, DM_address=0x2000, DM_in=0xCAFEF00D → MEM_write=1 and MEM_in=0xCAFEF00D held stable for 4 BUSY cycles; DM_ready at N+5.
- Contention: both enables held continuously for 6 transactions → grant order D,I,D,I,D,I with a one-cycle ready pulse each.
- Timeout: TIMEOUT=64, no ack → timeout_err and DM_ready pulse with DM_out=0xDEADBEEF. Repeat with ack in cycle 64 → no timeout_err; data taken from MEM_out.
- Mid-transaction reset: assert reset=0 in the 3rd BUSY cycle → MEM_enable=0 asynchronously; after release, no ready pulse, state IDLE, and a stray MEM_ack is ignored.
